// File: rtl/mpu_pkg.sv
// mpu_pkg: shared matrix geometry, op codes and host-port state encoding
package mpu_pkg;
  localparam int ELEM_W = 8;
  localparam int ELEMS = 25;
  localparam int MATRIX_W = ELEMS * ELEM_W;
  localparam int ADDR_W = 3;
  localparam int RD_LATENCY = 2;
  localparam int CNT_W = $clog2(ELEMS + 1);
  localparam int LAT_W = $clog2(RD_LATENCY + 2);
  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_READ = 1'b1;
  typedef enum logic [2:0] {IDLE, W_COLLECT, W_COMMIT, R_WAIT, R_STREAM} state_t;
endpackage

// File: rtl/matrix_host_port_if.sv
// matrix_host_port_if: host command, byte streams and shared-memory port bundled as one bus
//   slave  = the host port block (accepts cmd/in, drives out and memory)
//   master = the host plus memory side
interface matrix_host_port_if;
  import mpu_pkg::*;
  logic cmd_valid, cmd_ready, cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ELEM_W-1:0] in_data;
  logic in_valid, in_ready;
  logic [ELEM_W-1:0] out_data;
  logic out_valid, out_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [MATRIX_W-1:0] mem_wdata, mem_rdata;
  logic mem_wren, busy;
  modport slave (
    input cmd_valid, cmd_op, cmd_addr, in_data, in_valid, out_ready, mem_rdata,
    output cmd_ready, in_ready, out_data, out_valid, mem_addr, mem_wdata, mem_wren, busy
  );
  modport master (
    output cmd_valid, cmd_op, cmd_addr, in_data, in_valid, out_ready, mem_rdata,
    input cmd_ready, in_ready, out_data, out_valid, mem_addr, mem_wdata, mem_wren, busy
  );
endinterface

// File: rtl/matrix_byte_serializer.sv
// matrix_byte_serializer: captures a 200-bit matrix and streams it out low byte first
//   load captures rdata and raises out_valid; each out handshake shifts one element;
//   done flags the handshake of the final element
module matrix_byte_serializer import mpu_pkg::*; (
  input  logic                clock,
  input  logic                reset,
  input  logic                load,
  input  logic [MATRIX_W-1:0] rdata,
  input  logic                out_ready,
  output logic [ELEM_W-1:0]   out_data,
  output logic                out_valid,
  output logic                done
);
  logic [MATRIX_W-1:0] sh;
  logic [CNT_W-1:0] cnt;
  logic fire;
  assign fire = out_valid && out_ready;
  assign done = fire && cnt == CNT_W'(ELEMS - 1);
  assign out_data = sh[ELEM_W-1:0];
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      sh <= '0;
      cnt <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      sh <= rdata;
      cnt <= '0;
      out_valid <= 1'b1;
    end else if (fire) begin
      sh <= sh >> ELEM_W;
      cnt <= cnt + 1'b1;
      out_valid <= !done;
    end
endmodule

// File: rtl/matrix_host_port.sv
// matrix_host_port: host-side port of the shared matrix memory (byte stream <-> 200-bit word)
//   clock/reset: system clock, async active-high reset
//   bus: command handshake, input/output byte streams, registered memory port, busy
module matrix_host_port import mpu_pkg::*; (
  input logic clock,
  input logic reset,
  matrix_host_port_if.slave bus
);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [LAT_W-1:0] lat;
  logic [ADDR_W-1:0] mem_addr;
  logic [MATRIX_W-1:0] mem_wdata;
  logic mem_wren, load, done, cmd_fire, in_fire;
  assign cmd_fire = state == IDLE && bus.cmd_valid;
  assign in_fire = state == W_COLLECT && bus.in_valid;
  always_comb begin
    state_n = state;
    load = 1'b0;
    case (state)
      IDLE: state_n = bus.cmd_valid ? (bus.cmd_op == OP_WRITE ? W_COLLECT : R_WAIT) : IDLE;
      W_COLLECT: state_n = (in_fire && cnt == CNT_W'(ELEMS - 1)) ? W_COMMIT : W_COLLECT;
      W_COMMIT: state_n = IDLE;
      R_WAIT: begin
        load = lat == LAT_W'(RD_LATENCY);
        state_n = load ? R_STREAM : R_WAIT;
      end
      R_STREAM: state_n = done ? IDLE : R_STREAM;
      default: state_n = IDLE;
    endcase
  end
  // mem_wren is registered off the next state so it is high for exactly the commit cycle
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      lat <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_wren <= 1'b0;
    end else begin
      state <= state_n;
      mem_wren <= state_n == W_COMMIT;
      if (cmd_fire) begin
        mem_addr <= bus.cmd_addr;
        cnt <= '0;
        lat <= '0;
      end
      if (in_fire) begin
        mem_wdata[cnt*ELEM_W +: ELEM_W] <= bus.in_data;
        cnt <= cnt + 1'b1;
      end
      if (state == R_WAIT) lat <= lat + 1'b1;
    end
  matrix_byte_serializer u_ser (
    .clock(clock),
    .reset(reset),
    .load(load),
    .rdata(bus.mem_rdata),
    .out_ready(bus.out_ready),
    .out_data(bus.out_data),
    .out_valid(bus.out_valid),
    .done(done)
  );
  assign bus.cmd_ready = state == IDLE;
  assign bus.in_ready = state == W_COLLECT;
  assign bus.busy = state != IDLE;
  assign bus.mem_addr = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.mem_wren = mem_wren;
endmodule
